uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
// - Asynchronous serial receiver (8N1) that sits directly upstream of the PS/2 output transmitter.
// - Recovers bytes from the host UART line and presents each one as data plus a one-cycle rts strobe.
//   This is exactly the data/rts pair the PS/2 transmitter samples in its idle state.
// - Flags framing errors and rejects start-bit glitches, so line noise never reaches the PS/2 side.
// PARAMETERS
// - CLKS_PER_BIT  217  clk cycles per UART bit (25 MHz / 115200); legal range 8..65535
// PORTS
// - clk        in   1  system clock; all logic on posedge
// - rst_n      in   1  asynchronous, active-low reset
// - rx         in   1  raw UART line, asynchronous to clk, idle high
// - data       out  8  last good received byte, LSB first on the wire
// - rts        out  1  one-cycle strobe: data holds a new valid byte
// - frame_err  out  1  one-cycle strobe: stop bit sampled low, byte discarded
// BEHAVIOUR
// - Reset:
//   - rst_n low clears state to IDLE, counters to 0 and data to 8'h00.
//   - rts and frame_err go to 0; both synchronizer flops and the 3-bit sample history go to 1.
//   - Takes effect immediately, also mid-byte; a partial byte is dropped and no strobe is emitted.
// - Input conditioning:
//   - rx passes through 2 flops to give rx_s, then a 3-deep history.
//   - samp is the majority of the 3 history bits and is used for every bit decision.
// - Timing: bit counter clkd (16 b) counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (integer division).
// - State IDLE:
//   - Waits for a falling edge: previous rx_s==1 and current rx_s==0.
//   - On the edge: clkd<=0, goes to START.
//   - A line held low never retriggers until it has returned high.
// - State START:
//   - At clkd==HALF-1: if samp==1 (glitch) return to IDLE with no strobe.
//   - Otherwise clkd<=0, index<=0, go to DATA.
// - State DATA:
//   - At clkd==CLKS_PER_BIT-1 (mid-bit): shift samp into shreg[index], clkd<=0.
//   - index 0..7; after index 7, go to STOP.
// - State STOP:
//   - At clkd==CLKS_PER_BIT-1: if samp==1, data<=shreg and rts<=1 for exactly one cycle.
//   - Else frame_err<=1 for one cycle and data is unchanged.
//   - Both cases go to IDLE the same cycle.
// - Strobes:
//   - rts and frame_err are never high together; each is high at most once per frame.
//   - They clear the following cycle.
//   - data is stable from the rts cycle until the next rts.
// - Latency: rts asserts about 9.5 bit times + 3 clk (sync + history) after the rx falling edge.
// - Back-to-back frames:
//   - Return to IDLE at mid-stop-bit, so the next start edge is caught with no gap needed.
//   - Receiver tolerates about ±4% baud mismatch.
// - No flow control: the PS/2 side takes ~1.1 ms per byte. Host pacing is the system's job.
//   A byte arriving while PS/2 is busy is still strobed (and dropped downstream).
// TESTING (CLKS_PER_BIT=16 for all scenarios)
// - Send 0x41 (8N1, 16 clk/bit):
//   - exactly one rts pulse, 1 cycle wide, with data==8'h41
//   - frame_err stays 0
// - rx low for 4 clk then high: no rts, no frame_err, state back to IDLE; data unchanged.
// - Send 0x5A with stop bit forced 0:
//   - one frame_err pulse, no rts; data keeps its previous value
//   - rx then held low 100 clk: no further strobes
// - Back-to-back 0x00 then 0xFF, no idle gap: two rts pulses, data 8'h00 then 8'hFF, in order.
// - Assert rst_n low during data bit 4 of 0xA5:
//   - outputs return to reset values at once (async), no strobe
//   - a following 0x3C is received correctly
// - Send 0x55 at +3% and -3% bit period (timed 16.5 / 15.5 clk per bit): data==8'h55, one rts each.

Source files
------------

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, 3-sample majority filter, mid-bit sampling.
// Emits each good byte on data with a one-cycle rts strobe; bad stop bits give frame_err.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rts,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfCnt = 16'(CLKS_PER_BIT / 2 - 1);

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [2:0]  hist_q;
  logic [15:0] clkd_q, clkd_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        rts_q, rts_d;
  logic        ferr_q, ferr_d;
  logic        samp, fall;

  assign samp = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
  // hist_q[0] is the previous rx_s, so a held-low line never looks like a new edge
  assign fall = hist_q[0] & ~rx_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      hist_q    <= 3'b111;
      state_q   <= StIdle;
      clkd_q    <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rts_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      hist_q    <= {hist_q[1:0], rx_s_q};
      state_q   <= state_d;
      clkd_q    <= clkd_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rts_q     <= rts_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clkd_d  = clkd_q + 16'd1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    rts_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        clkd_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (clkd_q == HalfCnt) begin
          if (samp) begin
            state_d = StIdle;
          end else begin
            clkd_d  = '0;
            idx_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (clkd_q == LastCnt) begin
          shreg_d[idx_q] = samp;
          clkd_d         = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (clkd_q == LastCnt) begin
          clkd_d  = '0;
          state_d = StIdle;
          if (samp) begin
            data_d = shreg_q;
            rts_d  = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data      = data_q;
  assign rts       = rts_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clk/bit: good, glitch, framing-error,
// back-to-back, async-reset-mid-byte and +/-3% baud frames.
module tb_uart_rx_byte;

  localparam int unsigned Cpb = 16;
  localparam int Per = 160;  // clock period is 10 time units

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       rts;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;

  int rts_cnt   = 0;
  int ferr_cnt  = 0;
  int wide_cnt  = 0;
  int both_cnt  = 0;
  logic rts_prev  = 1'b0;
  logic ferr_prev = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_byte #(.CLKS_PER_BIT(Cpb)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .rts       (rts),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rts) begin
        rts_cnt++;
        got_q.push_back(data);
      end
      if (frame_err) ferr_cnt++;
      if ((rts && rts_prev) || (frame_err && ferr_prev)) wide_cnt++;
      if (rts && frame_err) both_cnt++;
    end
    rts_prev  = rts;
    ferr_prev = frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop);
    rx = 1'b0;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per);
    end
    rx = stop;
    #(per);
  endtask

  int rts0, ferr0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_data", 32'(data), 32'h00);
    check_eq("reset_rts", 32'(rts), 32'h0);
    check_eq("reset_ferr", 32'(frame_err), 32'h0);
    idle_clks(3);
    rst_n = 1'b1;
    idle_clks(10);

    // Good byte
    rts0 = rts_cnt; ferr0 = ferr_cnt;
    send_byte(8'h41, Per, 1'b1);
    idle_clks(20);
    check_eq("a41_rts_cnt", 32'(rts_cnt - rts0), 32'd1);
    check_eq("a41_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd0);
    check_eq("a41_data", 32'(data), 32'h41);

    // Start-bit glitch
    rts0 = rts_cnt; ferr0 = ferr_cnt;
    rx = 1'b0;
    idle_clks(4);
    rx = 1'b1;
    idle_clks(40);
    check_eq("glitch_rts_cnt", 32'(rts_cnt - rts0), 32'd0);
    check_eq("glitch_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd0);
    check_eq("glitch_data", 32'(data), 32'h41);

    // Framing error, then line held low
    rts0 = rts_cnt; ferr0 = ferr_cnt;
    send_byte(8'h5A, Per, 1'b0);
    idle_clks(5);
    check_eq("ferr_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd1);
    check_eq("ferr_rts_cnt", 32'(rts_cnt - rts0), 32'd0);
    check_eq("ferr_data", 32'(data), 32'h41);
    idle_clks(100);
    check_eq("low_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd1);
    check_eq("low_rts_cnt", 32'(rts_cnt - rts0), 32'd0);
    rx = 1'b1;
    idle_clks(40);

    // Back-to-back frames
    rts0 = rts_cnt;
    got_q.delete();
    send_byte(8'h00, Per, 1'b1);
    send_byte(8'hFF, Per, 1'b1);
    idle_clks(20);
    check_eq("b2b_rts_cnt", 32'(rts_cnt - rts0), 32'd2);
    if (got_q.size() >= 2) begin
      check_eq("b2b_first", 32'(got_q[0]), 32'h00);
      check_eq("b2b_second", 32'(got_q[1]), 32'hFF);
    end
    check_eq("b2b_data", 32'(data), 32'hFF);

    // Async reset during data bit 4 of 0xA5
    rts0 = rts_cnt; ferr0 = ferr_cnt;
    begin
      logic [7:0] b;
      b  = 8'hA5;
      rx = 1'b0;
      #(Per);
      for (int i = 0; i < 4; i++) begin
        rx = b[i];
        #(Per);
      end
      rx = b[4];
      #(Per / 2);
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_data", 32'(data), 32'h00);
    check_eq("rst_mid_rts", 32'(rts), 32'h0);
    check_eq("rst_mid_ferr", 32'(frame_err), 32'h0);
    rx = 1'b1;
    idle_clks(3);
    rst_n = 1'b1;
    idle_clks(40);
    check_eq("rst_mid_no_strobe", 32'(rts_cnt - rts0 + ferr_cnt - ferr0), 32'd0);
    send_byte(8'h3C, Per, 1'b1);
    idle_clks(20);
    check_eq("a3c_rts_cnt", 32'(rts_cnt - rts0), 32'd1);
    check_eq("a3c_data", 32'(data), 32'h3C);

    // Baud mismatch: slow then fast sender
    rts0 = rts_cnt; ferr0 = ferr_cnt;
    send_byte(8'h55, 165, 1'b1);
    idle_clks(20);
    check_eq("slow_rts_cnt", 32'(rts_cnt - rts0), 32'd1);
    check_eq("slow_data", 32'(data), 32'h55);
    rts0 = rts_cnt;
    send_byte(8'h55, 155, 1'b1);
    idle_clks(20);
    check_eq("fast_rts_cnt", 32'(rts_cnt - rts0), 32'd1);
    check_eq("fast_data", 32'(data), 32'h55);
    check_eq("baud_ferr_cnt", 32'(ferr_cnt - ferr0), 32'd0);

    check_eq("strobe_width", 32'(wide_cnt), 32'd0);
    check_eq("strobe_overlap", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
